pvr_obj_list_walker: RTL

Sequencer that walks one tile's PVR object list in VRAM and feeds the ISP parser one primitive at a time. It fetches list words, decodes triangle-strip, triangle-array, quad-array and block-link entries, and computes each primitive's parameter address. It pulses the parser's start, waits for that primitive to finish, then advances. It sits between the region-array walker (upstream) and the ISP parser (downstream), and owns the parser's `poly_addr`/`render_poly` inputs.

---
 rtl/pvr_obj_list_walker_if.sv | 21 ++
 rtl/pvr_obj_list_walker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pvr_obj_list_walker_if.sv
// Walker-side bus bundle: VRAM read channel plus the ISP parser start/done handshake.
// The walker drives through the master modport; memory and parser sit on the slave side.
interface pvr_obj_list_walker_if;
  logic        vram_rd;
  logic [23:0] vram_addr;
  logic [31:0] vram_din;
  logic        vram_ack;
  logic [23:0] poly_addr;
  logic        render_poly;
  logic        poly_done;

  modport master (
    output vram_rd, vram_addr, poly_addr, render_poly,
    input  vram_din, vram_ack, poly_done
  );

  modport slave (
    input  vram_rd, vram_addr, poly_addr, render_poly,
    output vram_din, vram_ack, poly_done
  );
endinterface

// File: rtl/pvr_obj_list_walker.sv
// Walks one tile's PVR object list and issues one primitive at a time to the ISP parser.
// Define PVR_OBJ_ARRAY_EN to decode triangle/quad array entries; otherwise they are no-ops.
module pvr_obj_list_walker #(
  parameter int unsigned MAX_ENTRIES = 1023
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [23:0]                  list_base,
  input  logic [23:0]                  param_base,
  pvr_obj_list_walker_if.master        bus,
  output logic [5:0]                   strip_mask,
  output logic                         shadow,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int unsigned CntW = $clog2(MAX_ENTRIES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWait,
    StFinish
  } state_e;

  state_e          state_q, state_d;
  logic [23:0]     cur_addr_q, cur_addr_d;
  logic [31:0]     entry_q, entry_d;
  logic [CntW-1:0] entry_cnt_q, entry_cnt_d;
  logic            overrun_q, overrun_d;
  logic [23:0]     poly_addr_q, poly_addr_d;
  logic [5:0]      strip_mask_q, strip_mask_d;
  logic            shadow_q, shadow_d;
  logic            goto_fetch;
  logic [23:0]     entry_poly_addr;

  assign entry_poly_addr = param_base + {1'b0, entry_q[20:0], 2'b00};

`ifdef PVR_OBJ_ARRAY_EN
  logic [4:0] prim_left_q, prim_left_d;
  logic [2:0] skip_q, skip_d;
  logic       quad_q, quad_d;
  logic [7:0] vtx_words;
  logic [7:0] nv_words;
  logic [7:0] stride_words;

  // Stride in words: 3 ISP/TSP words, 2 more for shadow, nv vertices of (3 + skip) words.
  assign vtx_words    = {5'd0, skip_q} + 8'd3;
  assign nv_words     = quad_q ? (vtx_words << 2) : (vtx_words + (vtx_words << 1));
  assign stride_words = 8'd3 + {6'd0, shadow_q, 1'b0} + nv_words;
`endif

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    entry_d      = entry_q;
    entry_cnt_d  = entry_cnt_q;
    overrun_d    = overrun_q;
    poly_addr_d  = poly_addr_q;
    strip_mask_d = strip_mask_q;
    shadow_d     = shadow_q;
`ifdef PVR_OBJ_ARRAY_EN
    prim_left_d  = prim_left_q;
    skip_d       = skip_q;
    quad_d       = quad_q;
`endif
    goto_fetch   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d  = list_base;
          entry_cnt_d = '0;
          overrun_d   = 1'b0;
          goto_fetch  = 1'b1;
        end
      end
      StFetch: begin
        if (bus.vram_ack) begin
          entry_d     = bus.vram_din;
          entry_cnt_d = entry_cnt_q + CntW'(1);
          state_d     = StDecode;
        end
      end
      StDecode: begin
        if (!entry_q[31]) begin
          if (entry_q[30:25] != 6'd0) begin
            poly_addr_d  = entry_poly_addr;
            strip_mask_d = entry_q[30:25];
            shadow_d     = entry_q[24];
`ifdef PVR_OBJ_ARRAY_EN
            prim_left_d  = 5'd1;
`endif
            state_d      = StIssue;
          end else begin
            cur_addr_d = cur_addr_q + 24'd4;
            goto_fetch = 1'b1;
          end
        end else if (entry_q[30:29] == 2'b11) begin
          if (entry_q[28]) begin
            state_d = StFinish;
          end else begin
            cur_addr_d = {entry_q[23:2], 2'b00};
            goto_fetch = 1'b1;
          end
`ifdef PVR_OBJ_ARRAY_EN
        end else if (!entry_q[30]) begin
          poly_addr_d  = entry_poly_addr;
          strip_mask_d = 6'd0;
          shadow_d     = entry_q[24];
          prim_left_d  = {1'b0, entry_q[28:25]} + 5'd1;
          skip_d       = entry_q[23:21];
          quad_d       = entry_q[29];
          state_d      = StIssue;
`endif
        end else begin
          cur_addr_d = cur_addr_q + 24'd4;
          goto_fetch = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        if (bus.poly_done) begin
`ifdef PVR_OBJ_ARRAY_EN
          prim_left_d = prim_left_q - 5'd1;
          if (prim_left_d != 5'd0) begin
            poly_addr_d = poly_addr_q + {14'd0, stride_words, 2'b00};
            state_d     = StIssue;
          end else begin
            cur_addr_d = cur_addr_q + 24'd4;
            goto_fetch = 1'b1;
          end
`else
          cur_addr_d = cur_addr_q + 24'd4;
          goto_fetch = 1'b1;
`endif
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Runaway guard sits on every path into FETCH.
    if (goto_fetch) begin
      if (entry_cnt_d == CntW'(MAX_ENTRIES)) begin
        overrun_d = 1'b1;
        state_d   = StFinish;
      end else begin
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cur_addr_q   <= '0;
      entry_q      <= '0;
      entry_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      poly_addr_q  <= '0;
      strip_mask_q <= '0;
      shadow_q     <= 1'b0;
`ifdef PVR_OBJ_ARRAY_EN
      prim_left_q  <= '0;
      skip_q       <= '0;
      quad_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      entry_q      <= entry_d;
      entry_cnt_q  <= entry_cnt_d;
      overrun_q    <= overrun_d;
      poly_addr_q  <= poly_addr_d;
      strip_mask_q <= strip_mask_d;
      shadow_q     <= shadow_d;
`ifdef PVR_OBJ_ARRAY_EN
      prim_left_q  <= prim_left_d;
      skip_q       <= skip_d;
      quad_q       <= quad_d;
`endif
    end
  end

  assign bus.vram_rd     = (state_q == StFetch);
  assign bus.vram_addr   = cur_addr_q;
  assign bus.poly_addr   = poly_addr_q;
  assign bus.render_poly = (state_q == StIssue);
  assign strip_mask      = strip_mask_q;
  assign shadow          = shadow_q;
  assign busy            = (state_q != StIdle) && (state_q != StFinish);
  assign done            = (state_q == StFinish);
  assign overrun         = overrun_q;

endmodule
